// File: rtl/reg_dump_reader.sv
// ---------------------------------------------------------------------------
// reg_dump_reader
//
// Debug read-back engine for the integer register file. When started, it
// walks an inclusive address range (which may wrap past the top register)
// through one asynchronous register-file read port. Each (address, data)
// pair is streamed out over a valid/ready interface to the debug/trace unit.
//
// Ports
//   clk         clock; all state updates on the rising edge
//   rst         asynchronous, active-low reset
//   start       begin a dump (only honoured while idle)
//   abort       synchronous cancel; overrides every other input
//   first_addr  first register of the range (latched on accepted start)
//   last_addr   last register of the range, inclusive (latched likewise)
//   raddr       register-file read address
//   rdata       register-file read data, combinational from raddr
//   dump_valid  output word valid
//   dump_ready  consumer accepts the output word
//   dump_addr   register address of the current output word
//   dump_data   register value of the current output word
//   busy        high whenever a dump is in progress (state != IDLE)
//   done        one-cycle pulse after the final word has been accepted
// ---------------------------------------------------------------------------
module reg_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Address increment modulo NUM_REGS, so a range like 30..1 walks
    // 30, 31, 0, 1 even if NUM_REGS is not a power of two.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(NUM_REGS - 1)) begin
            return '0;
        end
        return a + 1'b1;
    endfunction

    // ---------------------------------------------------------------------
    // Next-state and datapath update logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_d      = last_q;
        dump_addr_d = dump_addr_q;
        data_d      = data_q;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    addr_d  = first_addr;
                    last_d  = last_addr;
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    // Snapshot of the register at the end of this cycle.
                    data_d      = rdata;
                    dump_addr_d = addr_q;
                    state_d     = SEND;
                end
            end

            SEND: begin
                // abort wins even when the consumer is ready this cycle:
                // the word in flight counts as not transferred.
                if (abort) begin
                    state_d = IDLE;
                end else if (dump_ready) begin
                    if (addr_q == last_q) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = next_addr(addr_q);
                        state_d = FETCH;
                    end
                end
            end

            DONE: begin
                // abort has no effect here; done is already being reported.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_q      <= '0;
            dump_addr_q <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            dump_addr_q <= dump_addr_d;
            data_q      <= data_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: all decoded from registers, no input-to-output path except
    // through the external register file (raddr -> rdata).
    // ---------------------------------------------------------------------
    assign raddr      = addr_q;
    assign dump_addr  = dump_addr_q;
    assign dump_data  = data_q;
    assign dump_valid = (state_q == SEND);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        busy;
    logic        done;

    // Register file model: x0 reads as zero, others from the array.
    logic [31:0] regs [32];
    assign rdata = (raddr == 5'd0) ? 32'd0 : regs[raddr];

    reg_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr),
        .raddr(raddr), .rdata(rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;
    int done_cnt = 0;
    int accepted = 0;

    logic [4:0]  exp_addr_q [$];
    logic [31:0] exp_data_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: list every register of the inclusive, wrapping range.
    task automatic push_range(input logic [4:0] f, input logic [4:0] l);
        int a;
        a = int'(f);
        forever begin
            exp_addr_q.push_back(5'(a));
            exp_data_q.push_back((a == 0) ? 32'd0 : regs[a]);
            if (a == int'(l)) break;
            a = (a + 1) % 32;
        end
    endtask

    function automatic int range_len(input logic [4:0] f, input logic [4:0] l);
        return ((int'(l) - int'(f) + 32) % 32) + 1;
    endfunction

    // Monitor: sample at negedge, pop expected word on every handshake.
    bit          held = 0;
    logic [4:0]  held_addr;
    logic [31:0] held_data;

    always @(negedge clk) begin
        if (!rst) begin
            held = 0;
        end else begin
            if (done) done_cnt++;
            if (dump_valid) begin
                if (held) begin
                    check("hold_addr", 64'(dump_addr), 64'(held_addr));
                    check("hold_data", 64'(dump_data), 64'(held_data));
                end
                if (dump_ready && !abort) begin
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL extra_word: got addr %0d data 0x%0h, expected no word", dump_addr, dump_data);
                    end else begin
                        logic [4:0]  ea;
                        logic [31:0] ed;
                        ea = exp_addr_q.pop_front();
                        ed = exp_data_q.pop_front();
                        check("word_addr", 64'(dump_addr), 64'(ea));
                        check("word_data", 64'(dump_data), 64'(ed));
                    end
                    accepted++;
                    held = 0;
                end else begin
                    held      = 1;
                    held_addr = dump_addr;
                    held_data = dump_data;
                end
            end else begin
                held = 0;
            end
        end
    end

    // Run one dump to completion. Called at posedge+1.
    task automatic do_dump(input logic [4:0] f, input logic [4:0] l,
                           input bit rnd, input bit restart, output int cyc);
        int d0;
        d0 = done_cnt;
        push_range(f, l);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (busy && cyc < 2000) begin
            dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start      = restart && dump_valid;
            if (restart) begin
                first_addr = 5'd0;
                last_addr  = 5'd31;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("dump_ends", 64'(busy), 64'd0);
        check("queue_drained", 64'(exp_addr_q.size()), 64'd0);
        check("done_pulses", 64'(done_cnt - d0), 64'd1);
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    initial begin
        int cyc;
        int a0;
        int d0;
        int n;

        rst = 1'b0; start = 1'b0; abort = 1'b0; dump_ready = 1'b0;
        first_addr = '0; last_addr = '0;
        regs[0] = 32'd0;
        for (int i = 1; i < 32; i++) regs[i] = 32'h1000_0000 + i;

        #12;
        check("rst_valid", 64'(dump_valid), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_raddr", 64'(raddr), 64'd0);
        check("rst_daddr", 64'(dump_addr), 64'd0);
        check("rst_ddata", 64'(dump_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Full dump 0..31 with ready high.
        do_dump(5'd0, 5'd31, 1'b0, 1'b0, cyc);
        check("full_cycles", 64'(cyc), 64'(2 * range_len(5'd0, 5'd31) + 2));

        // Backpressure on 5..7.
        do_dump(5'd5, 5'd7, 1'b1, 1'b0, cyc);

        // Wrap-around 30..1.
        do_dump(5'd30, 5'd1, 1'b0, 1'b0, cyc);
        check("wrap_cycles", 64'(cyc), 64'(2 * range_len(5'd30, 5'd1) + 2));

        // Single word with restart attempt during SEND.
        do_dump(5'd9, 5'd9, 1'b0, 1'b1, cyc);
        check("single_cycles", 64'(cyc), 64'd4);
        repeat (3) @(posedge clk);
        #1;
        check("restart_ignored", 64'(busy), 64'd0);

        // Random ranges with random backpressure.
        for (int k = 0; k < 4; k++) begin
            for (int i = 1; i < 32; i++) regs[i] = $urandom;
            do_dump(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1, 1'b0, cyc);
        end

        // Abort during the 3rd word of 0..31, with ready high.
        a0 = accepted;
        push_range(5'd0, 5'd31);
        first_addr = 5'd0; last_addr = 5'd31; start = 1'b1; dump_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!((accepted - a0) == 2 && dump_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_reach_word3", 64'(dump_valid), 64'd1);
        d0 = done_cnt;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid", 64'(dump_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_left", 64'(exp_addr_q.size()), 64'd30);
        exp_addr_q.delete();
        exp_data_q.delete();
        do_dump(5'd4, 5'd4, 1'b0, 1'b0, cyc);

        // abort together with start in IDLE.
        first_addr = 5'd2; last_addr = 5'd3; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("abort_beats_start", 64'(busy), 64'd0);

        // Reset mid-dump.
        push_range(5'd0, 5'd31);
        first_addr = 5'd0; last_addr = 5'd31; start = 1'b1; dump_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 64'(dump_valid), 64'd0);
        check("mid_rst_busy",  64'(busy), 64'd0);
        check("mid_rst_done",  64'(done), 64'd0);
        check("mid_rst_raddr", 64'(raddr), 64'd0);
        check("mid_rst_daddr", 64'(dump_addr), 64'd0);
        check("mid_rst_ddata", 64'(dump_data), 64'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", 64'(busy), 64'd0);

        // Write race on x3: write during FETCH is seen, write after is not.
        d0 = done_cnt;
        regs[3] = 32'd0;
        first_addr = 5'd3; last_addr = 5'd3; start = 1'b1; dump_ready = 1'b0;
        exp_addr_q.push_back(5'd3);
        exp_data_q.push_back(32'hDEAD_BEEF);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk) regs[3] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        @(negedge clk) regs[3] = 32'h0000_1234;
        @(posedge clk); #1;
        dump_ready = 1'b1;
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("race_ends", 64'(busy), 64'd0);
        check("race_drained", 64'(exp_addr_q.size()), 64'd0);
        check("race_done", 64'(done_cnt - d0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
